// File: rtl/can_fd_tx_pkg.sv
// Shared types and constants for the CAN FD bit-level transmitter.
// Bit timing is carried as one struct so a whole bit's timing is latched in one step.
package can_fd_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BIT   = 2'd1,
    STUFF = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [5:0] brp;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
  } bit_timing_t;

  localparam int STUFF_LIMIT = 5;

  function automatic bit_timing_t pick_timing(input logic fd,
                                              input bit_timing_t nom,
                                              input bit_timing_t dat);
    return fd ? dat : nom;
  endfunction

endpackage

// File: rtl/can_fd_tq_timer.sv
// Time-quantum timer for one bit: prescaler plus quantum counter, restarted at every bit start.
// Strobes the sample point (end of tseg1) and the last clock of the bit.
module can_fd_tq_timer
  import can_fd_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        res_n,
  input  logic        i_load,
  input  logic        i_restart,
  input  bit_timing_t i_timing,
  output logic        o_sample_pt,
  output logic        o_bit_end
);

  bit_timing_t r_timing;
  logic [6:0]  r_presc;
  logic [4:0]  r_tq;

  logic [6:0]  w_presc_max;
  logic [4:0]  w_tq_sample;
  logic [4:0]  w_tq_last;
  logic        w_tq_tick;

  // A quantum is 2*(brp+1) clocks, so the prescaler wraps at 2*brp+1.
  assign w_presc_max = {r_timing.brp, 1'b1};
  assign w_tq_sample = {1'b0, r_timing.tseg1} + 5'd2;
  assign w_tq_last   = {1'b0, r_timing.tseg1} + {2'b00, r_timing.tseg2} + 5'd2;
  assign w_tq_tick   = (r_presc == w_presc_max);

  always_ff @(posedge clk_i or negedge res_n) begin
    if (!res_n) begin
      r_timing <= '0;
      r_presc  <= '0;
      r_tq     <= '0;
    end else begin
      if (i_load) begin
        r_timing <= i_timing;
      end
      if (i_load || i_restart) begin
        r_presc <= '0;
        r_tq    <= '0;
      end else if (w_tq_tick) begin
        r_presc <= '0;
        r_tq    <= (r_tq == w_tq_last) ? 5'd0 : r_tq + 5'd1;
      end else begin
        r_presc <= r_presc + 7'd1;
      end
    end
  end

  assign o_sample_pt = (r_presc == 7'd0) && (r_tq == w_tq_sample);
  assign o_bit_end   = w_tq_tick && (r_tq == w_tq_last);

endmodule

// File: rtl/can_fd_bit_tx.sv
// CAN FD bit transmitter: takes unstuffed bits by valid/ready, inserts dynamic stuff bits,
// times each bit with nominal or data-phase timing and monitors the bus at the sample point.
module can_fd_bit_tx
  import can_fd_tx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       res_n,
  input  logic       enable_i,
  input  logic [5:0] brp_nom_i,
  input  logic [3:0] tseg1_nom_i,
  input  logic [2:0] tseg2_nom_i,
  input  logic [5:0] brp_fd_i,
  input  logic [3:0] tseg1_fd_i,
  input  logic [2:0] tseg2_fd_i,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  output logic       bit_ready_o,
  input  logic       stuff_en_i,
  input  logic       fd_phase_i,
  input  logic       arb_i,
  input  logic       last_i,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       arb_lost_o,
  output logic       bit_err_o,
  output logic       underrun_o
);

  tx_state_e              r_state;
  tx_state_e              w_state_next;
  logic                   r_tx;
  logic                   r_last_bit;
  logic                   r_is_last;
  logic                   r_arb;
  logic                   r_fd;
  logic [2:0]             r_stuff_cnt;
  logic [SYNC_STAGES-1:0] r_sync;

  logic        w_rx;
  logic        w_sample_pt;
  logic        w_bit_end;
  logic        w_start_bit;
  logic        w_start_stuff;
  logic        w_leave;
  logic        w_stuff_due;
  logic        w_check;
  logic        w_arb_loss;
  logic [2:0]  w_cnt_next;
  bit_timing_t w_nom;
  bit_timing_t w_fd;
  bit_timing_t w_timing;

  assign w_nom    = '{brp: brp_nom_i, tseg1: tseg1_nom_i, tseg2: tseg2_nom_i};
  assign w_fd     = '{brp: brp_fd_i, tseg1: tseg1_fd_i, tseg2: tseg2_fd_i};
  assign w_timing = pick_timing(fd_phase_i, w_nom, w_fd);

  always_ff @(posedge clk_i or negedge res_n) begin
    if (!res_n) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= rx_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_rx = r_sync[SYNC_STAGES-1];

  can_fd_tq_timer u_timer (
    .clk_i       (clk_i),
    .res_n       (res_n),
    .i_load      (w_start_bit),
    .i_restart   (w_start_stuff),
    .i_timing    (w_timing),
    .o_sample_pt (w_sample_pt),
    .o_bit_end   (w_bit_end)
  );

  // Data-phase bits are not compared; a dominant echo on a recessive arbitration bit loses.
  assign w_check     = (r_state != IDLE) && w_sample_pt && !r_fd && (w_rx != r_tx);
  assign w_arb_loss  = w_check && r_tx && r_arb;
  assign w_stuff_due = (r_stuff_cnt == 3'(STUFF_LIMIT)) && !r_is_last;
  assign w_leave     = (r_state != IDLE) && (w_state_next == IDLE);

  always_comb begin
    w_cnt_next = 3'd0;
    if (stuff_en_i) begin
      w_cnt_next = ((r_stuff_cnt != 3'd0) && (bit_i == r_last_bit)) ? r_stuff_cnt + 3'd1 : 3'd1;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bit_ready_o   = 1'b0;
    done_o        = 1'b0;
    arb_lost_o    = 1'b0;
    bit_err_o     = 1'b0;
    underrun_o    = 1'b0;
    w_start_bit   = 1'b0;
    w_start_stuff = 1'b0;
    case (r_state)
      IDLE: begin
        bit_ready_o = enable_i;
        if (enable_i && bit_valid_i) begin
          w_start_bit  = 1'b1;
          w_state_next = BIT;
        end
      end
      BIT, STUFF: begin
        if (w_arb_loss) begin
          arb_lost_o   = 1'b1;
          w_state_next = IDLE;
        end else if (!enable_i) begin
          w_state_next = IDLE;
        end else begin
          bit_err_o = w_check;
          if (w_bit_end) begin
            if (w_stuff_due) begin
              w_start_stuff = 1'b1;
              w_state_next  = STUFF;
            end else if (r_is_last) begin
              done_o       = 1'b1;
              w_state_next = IDLE;
            end else begin
              bit_ready_o = 1'b1;
              if (bit_valid_i) begin
                w_start_bit  = 1'b1;
                w_state_next = BIT;
              end else begin
                underrun_o   = 1'b1;
                w_state_next = IDLE;
              end
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_n) begin
    if (!res_n) begin
      r_state     <= IDLE;
      r_tx        <= 1'b1;
      r_last_bit  <= 1'b1;
      r_is_last   <= 1'b0;
      r_arb       <= 1'b0;
      r_fd        <= 1'b0;
      r_stuff_cnt <= 3'd0;
    end else begin
      r_state <= w_state_next;
      if (w_start_bit) begin
        r_tx        <= bit_i;
        r_last_bit  <= bit_i;
        r_is_last   <= last_i;
        r_arb       <= arb_i;
        r_fd        <= fd_phase_i;
        r_stuff_cnt <= w_cnt_next;
      end else if (w_start_stuff) begin
        // Stuff bit keeps the previous bit's flags and timing and opens a new run of one.
        r_tx        <= ~r_last_bit;
        r_last_bit  <= ~r_last_bit;
        r_stuff_cnt <= 3'd1;
      end else if (w_leave) begin
        r_tx        <= 1'b1;
        r_last_bit  <= 1'b1;
        r_stuff_cnt <= 3'd0;
      end
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_can_fd_bit_tx.sv
// Self-checking bench for can_fd_bit_tx: frames are expanded into an expected bus
// waveform (stuffing and bit lengths) and compared with the captured tx_o per bit.
module tb_can_fd_bit_tx;

  logic       clk_i = 1'b0;
  logic       res_n;
  logic       enable_i;
  logic [5:0] brp_nom_i, brp_fd_i;
  logic [3:0] tseg1_nom_i, tseg1_fd_i;
  logic [2:0] tseg2_nom_i, tseg2_fd_i;
  logic       bit_i, bit_valid_i, bit_ready_o;
  logic       stuff_en_i, fd_phase_i, arb_i, last_i;
  logic       rx_i, tx_o, busy_o, done_o, arb_lost_o, bit_err_o, underrun_o;

  int rx_mode;  // 0 echo, 1 force dominant, 2 force recessive, 3 inverted echo
  assign rx_i = (rx_mode == 1) ? 1'b0 : (rx_mode == 2) ? 1'b1 : (rx_mode == 3) ? ~tx_o : tx_o;

  always #5 clk_i = ~clk_i;

  can_fd_bit_tx #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .res_n(res_n), .enable_i(enable_i),
    .brp_nom_i(brp_nom_i), .tseg1_nom_i(tseg1_nom_i), .tseg2_nom_i(tseg2_nom_i),
    .brp_fd_i(brp_fd_i), .tseg1_fd_i(tseg1_fd_i), .tseg2_fd_i(tseg2_fd_i),
    .bit_i(bit_i), .bit_valid_i(bit_valid_i), .bit_ready_o(bit_ready_o),
    .stuff_en_i(stuff_en_i), .fd_phase_i(fd_phase_i), .arb_i(arb_i), .last_i(last_i),
    .rx_i(rx_i), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o),
    .arb_lost_o(arb_lost_o), .bit_err_o(bit_err_o), .underrun_o(underrun_o)
  );

  typedef struct {
    bit b;
    bit st;
    bit fd;
    bit arb;
    bit last;
    int frc;
  } fbit_t;

  fbit_t frame_q[$];
  bit    exp_val[$];
  int    exp_len[$];
  bit    tx_cap[$];
  bit    busy_cap[$];
  int    err_cyc_q[$];
  int    hs, done_cnt, arb_cnt, und_cnt, done_cyc, arb_cyc, und_cyc;
  bit    finished;
  int    abort_kind, abort_cyc;
  logic [5:0] rst_obs;
  int    checks = 0;
  int    errors = 0;

  function automatic int bit_len(input bit fd);
    if (fd) return 2 * (int'(brp_fd_i) + 1) * (int'(tseg1_fd_i) + int'(tseg2_fd_i) + 3);
    return 2 * (int'(brp_nom_i) + 1) * (int'(tseg1_nom_i) + int'(tseg2_nom_i) + 3);
  endfunction

  // Expected bus bit sequence: every frame bit, plus a complement after five equal stuffed bits.
  function automatic void build_expected();
    int run = 0;
    bit prev = 1'b1;
    exp_val.delete();
    exp_len.delete();
    foreach (frame_q[i]) begin
      exp_val.push_back(frame_q[i].b);
      exp_len.push_back(bit_len(frame_q[i].fd));
      if (frame_q[i].st) run = (run > 0 && frame_q[i].b == prev) ? run + 1 : 1;
      else run = 0;
      prev = frame_q[i].b;
      if (run == 5 && !frame_q[i].last) begin
        exp_val.push_back(~prev);
        exp_len.push_back(bit_len(frame_q[i].fd));
        prev = ~prev;
        run = 1;
      end
    end
  endfunction

  function automatic int exp_total();
    int s = 0;
    foreach (exp_len[j]) s += exp_len[j];
    return s;
  endfunction

  function automatic int first_bad_bit();
    int pos = 0;
    foreach (exp_val[j]) begin
      for (int c = 0; c < exp_len[j]; c++) begin
        if (pos + c >= tx_cap.size()) return j;
        if (tx_cap[pos + c] !== exp_val[j]) return j;
      end
      pos += exp_len[j];
    end
    return -1;
  endfunction

  function automatic fbit_t mk(input bit b, input bit st, input bit fd, input bit arb,
                               input bit last, input int frc);
    fbit_t f;
    f.b = b; f.st = st; f.fd = fd; f.arb = arb; f.last = last; f.frc = frc;
    return f;
  endfunction

  task automatic run_frame(input int max_cycles);
    int cyc = -1;
    bit end_seen = 1'b0;
    bit stop = 1'b0;
    tx_cap.delete(); busy_cap.delete(); err_cyc_q.delete();
    hs = 0; done_cnt = 0; arb_cnt = 0; und_cnt = 0;
    done_cyc = -1; arb_cyc = -1; und_cyc = -1; finished = 1'b0;
    for (int k = 0; k < max_cycles && !stop; k++) begin
      @(negedge clk_i);
      if (hs > 0) cyc++;
      if (end_seen) stop = 1'b1;
      if (!end_seen && hs < frame_q.size()) begin
        bit_valid_i = 1'b1;
        bit_i       = frame_q[hs].b;
        stuff_en_i  = frame_q[hs].st;
        fd_phase_i  = frame_q[hs].fd;
        arb_i       = frame_q[hs].arb;
        last_i      = frame_q[hs].last;
      end else begin
        bit_valid_i = 1'b0;
      end
      if (abort_kind == 1 && hs > 0 && cyc == abort_cyc && !end_seen) begin
        enable_i = 1'b0;
        end_seen = 1'b1;
      end
      #1;
      if (hs > 0) begin
        tx_cap.push_back(tx_o);
        busy_cap.push_back(busy_o);
        if (done_o)     begin done_cnt++; done_cyc = cyc; end_seen = 1'b1; end
        if (arb_lost_o) begin arb_cnt++;  arb_cyc = cyc;  end_seen = 1'b1; end
        if (underrun_o) begin und_cnt++;  und_cyc = cyc;  end_seen = 1'b1; end
        if (bit_err_o)  err_cyc_q.push_back(cyc);
      end
      if (bit_valid_i && bit_ready_o) begin
        hs++;
        rx_mode = frame_q[hs-1].frc;
      end
      if (abort_kind == 2 && hs > 0 && cyc == abort_cyc) begin
        #2 res_n = 1'b0;
        #1 rst_obs = {tx_o, busy_o, done_o, arb_lost_o, bit_err_o, underrun_o};
        stop = 1'b1;
      end
    end
    finished    = stop;
    bit_valid_i = 1'b0;
    rx_mode     = 0;
    enable_i    = 1'b1;
    abort_kind  = 0;
  endtask

  task automatic set_nominal_timing();
    brp_nom_i = 6'd0; tseg1_nom_i = 4'd3; tseg2_nom_i = 3'd2;
    brp_fd_i  = 6'd0; tseg1_fd_i  = 4'd1; tseg2_fd_i  = 3'd0;
  endtask

  task automatic test_reset();
    res_n = 1'b0; enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_o); end
    checks++;
    if ({busy_o, done_o, arb_lost_o, bit_err_o, underrun_o, bit_ready_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {busy_o, done_o, arb_lost_o, bit_err_o, underrun_o, bit_ready_o});
    end
    res_n = 1'b1; enable_i = 1'b1;
    @(negedge clk_i); #1;
    checks++;
    if (bit_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", bit_ready_o); end
  endtask

  task automatic test_nominal();
    int bad;
    set_nominal_timing();
    frame_q.delete();
    frame_q.push_back(mk(1, 0, 0, 0, 0, 0));
    frame_q.push_back(mk(0, 0, 0, 0, 0, 0));
    frame_q.push_back(mk(1, 0, 0, 0, 1, 0));
    build_expected();
    run_frame(300);
    bad = first_bad_bit();
    checks++;
    if (bad !== -1) begin errors++; $display("FAIL nominal_wave: first bad bit %0d expected -1", bad); end
    checks++;
    if (done_cyc !== 47) begin errors++; $display("FAIL nominal_done: got cycle %0d expected 47", done_cyc); end
    checks++;
    if (hs !== 3) begin errors++; $display("FAIL nominal_handshakes: got %0d expected 3", hs); end
    checks++;
    if (busy_cap.size() < 49 || busy_cap[48] !== 1'b0 || busy_cap[47] !== 1'b1) begin
      errors++; $display("FAIL nominal_busy: busy around done wrong, captured %0d cycles", busy_cap.size());
    end
  endtask

  task automatic test_stuff(input string tag);
    int bad;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(mk(0, 1, 0, 0, i == 5, 0));
    build_expected();
    run_frame(400);
    bad = first_bad_bit();
    checks++;
    if (bad !== -1) begin errors++; $display("FAIL %s_wave: first bad bit %0d expected -1", tag, bad); end
    checks++;
    if (hs !== 6) begin errors++; $display("FAIL %s_handshakes: got %0d expected 6", tag, hs); end
    checks++;
    if (done_cyc !== 7 * 16 - 1) begin
      errors++; $display("FAIL %s_done: got cycle %0d expected %0d", tag, done_cyc, 7 * 16 - 1);
    end
  endtask

  task automatic test_fd_phase();
    int bad;
    set_nominal_timing();
    frame_q.delete();
    frame_q.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) frame_q.push_back(mk(1'($urandom), 0, 1, 0, i == 2, 3));
    build_expected();
    run_frame(300);
    bad = first_bad_bit();
    checks++;
    if (bad !== -1) begin errors++; $display("FAIL fd_wave: first bad bit %0d expected -1", bad); end
    checks++;
    if (done_cyc !== 16 + 3 * 8 - 1) begin
      errors++; $display("FAIL fd_done: got cycle %0d expected %0d", done_cyc, 16 + 3 * 8 - 1);
    end
    checks++;
    if (err_cyc_q.size() !== 0) begin
      errors++; $display("FAIL fd_no_bit_err: got %0d pulses expected 0", err_cyc_q.size());
    end
  endtask

  task automatic test_arb_lost();
    for (int t = 0; t < 2; t++) begin
      int pre = $urandom_range(0, 2);
      int exp_cyc = pre * 16 + 10;
      set_nominal_timing();
      frame_q.delete();
      for (int i = 0; i < pre; i++) frame_q.push_back(mk(0, 0, 0, 1, 0, 0));
      frame_q.push_back(mk(1, 0, 0, 1, 0, 1));
      frame_q.push_back(mk(1, 0, 0, 1, 0, 0));
      frame_q.push_back(mk(0, 0, 0, 1, 1, 0));
      run_frame(300);
      checks++;
      if (arb_cyc !== exp_cyc || arb_cnt !== 1) begin
        errors++; $display("FAIL arb_lost_cycle: got %0d (x%0d) expected %0d (x1)", arb_cyc, arb_cnt, exp_cyc);
      end
      checks++;
      if (tx_cap.size() < exp_cyc + 2 || tx_cap[exp_cyc + 1] !== 1'b1 || busy_cap[exp_cyc + 1] !== 1'b0) begin
        errors++; $display("FAIL arb_lost_release: tx/busy after loss wrong, captured %0d cycles", tx_cap.size());
      end
      checks++;
      if (err_cyc_q.size() !== 0) begin
        errors++; $display("FAIL arb_lost_no_err: got %0d bit_err pulses expected 0", err_cyc_q.size());
      end
    end
  endtask

  task automatic test_underrun();
    set_nominal_timing();
    frame_q.delete();
    for (int i = 0; i < 3; i++) frame_q.push_back(mk(1'($urandom), 0, 0, 0, 0, 0));
    run_frame(300);
    checks++;
    if (und_cyc !== 47 || und_cnt !== 1) begin
      errors++; $display("FAIL underrun_pulse: got cycle %0d (x%0d) expected 47 (x1)", und_cyc, und_cnt);
    end
    checks++;
    if (busy_cap.size() < 49 || busy_cap[48] !== 1'b0 || tx_cap[48] !== 1'b1 || done_cnt !== 0) begin
      errors++; $display("FAIL underrun_idle: not idle after underrun, done pulses %0d", done_cnt);
    end
  endtask

  task automatic test_bit_err();
    int bad;
    set_nominal_timing();
    frame_q.delete();
    frame_q.push_back(mk(0, 0, 0, 0, 0, 2));
    frame_q.push_back(mk(1, 0, 0, 0, 0, 1));
    frame_q.push_back(mk(0, 0, 0, 0, 1, 0));
    build_expected();
    run_frame(300);
    checks++;
    if (err_cyc_q.size() !== 2 || err_cyc_q[0] !== 10 || err_cyc_q[1] !== 26) begin
      errors++; $display("FAIL bit_err_pulses: got %0d pulses expected 2 at cycles 10 and 26", err_cyc_q.size());
    end
    bad = first_bad_bit();
    checks++;
    if (bad !== -1 || done_cyc !== 47) begin
      errors++; $display("FAIL bit_err_continue: bad bit %0d done %0d expected -1 and 47", bad, done_cyc);
    end
  endtask

  task automatic test_enable_abort();
    set_nominal_timing();
    frame_q.delete();
    frame_q.push_back(mk(0, 0, 0, 0, 0, 0));
    frame_q.push_back(mk(0, 0, 0, 0, 0, 2));
    frame_q.push_back(mk(0, 0, 0, 0, 1, 0));
    abort_kind = 1; abort_cyc = 26;
    run_frame(300);
    checks++;
    if (tx_cap.size() < 28 || busy_cap[27] !== 1'b0 || tx_cap[27] !== 1'b1) begin
      errors++; $display("FAIL abort_idle: tx/busy after enable low wrong, captured %0d cycles", tx_cap.size());
    end
    checks++;
    if (done_cnt + arb_cnt + und_cnt + err_cyc_q.size() !== 0) begin
      errors++; $display("FAIL abort_no_pulse: got %0d pulses expected 0",
                         done_cnt + arb_cnt + und_cnt + err_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    set_nominal_timing();
    frame_q.delete();
    for (int i = 0; i < 4; i++) frame_q.push_back(mk(0, 1, 0, 0, 0, 0));
    abort_kind = 2; abort_cyc = 3 * 16 + 5;
    run_frame(300);
    checks++;
    if (rst_obs !== 6'b100000) begin
      errors++; $display("FAIL reset_mid_outputs: got %b expected 100000", rst_obs);
    end
    @(negedge clk_i);
    res_n = 1'b1;
    @(negedge clk_i);
    test_stuff("reset_restart");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int len = $urandom_range(8, 24);
      int fd_lo = $urandom_range(3, len - 2);
      int fd_hi = $urandom_range(fd_lo, len - 1);
      bit prev = 1'b0;
      int bad;
      brp_nom_i = 6'($urandom_range(0, 1)); tseg1_nom_i = 4'($urandom_range(0, 5));
      tseg2_nom_i = 3'($urandom_range(0, 3));
      brp_fd_i = 6'd0; tseg1_fd_i = 4'($urandom_range(0, 3)); tseg2_fd_i = 3'($urandom_range(0, 2));
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
        bit b = (i == 0) ? 1'b0 : (($urandom_range(0, 3) == 0) ? ~prev : prev);
        frame_q.push_back(mk(b, i < len - 3, (i >= fd_lo && i <= fd_hi), i < 3, i == len - 1, 0));
        prev = b;
      end
      build_expected();
      run_frame(4000);
      bad = first_bad_bit();
      checks++;
      if (!finished || bad !== -1) begin
        errors++; $display("FAIL random_wave[%0d]: finished %0d first bad bit %0d expected -1", f, finished, bad);
      end
      checks++;
      if (hs !== len || done_cyc !== exp_total() - 1) begin
        errors++; $display("FAIL random_done[%0d]: hs %0d done %0d expected hs %0d done %0d",
                           f, hs, done_cyc, len, exp_total() - 1);
      end
      checks++;
      if (err_cyc_q.size() + arb_cnt + und_cnt !== 0) begin
        errors++; $display("FAIL random_pulses[%0d]: got %0d error pulses expected 0",
                           f, err_cyc_q.size() + arb_cnt + und_cnt);
      end
    end
  endtask

  initial begin
    rx_mode = 0; abort_kind = 0; abort_cyc = 0;
    bit_i = 1'b1; bit_valid_i = 1'b0; stuff_en_i = 1'b0; fd_phase_i = 1'b0;
    arb_i = 1'b0; last_i = 1'b0;
    set_nominal_timing();
    test_reset();
    test_nominal();
    test_stuff("stuff");
    test_fd_phase();
    test_arb_lost();
    test_underrun();
    test_bit_err();
    test_enable_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_fd_bit_tx.md
# can_fd_bit_tx

Bit-level CAN FD transmitter: the transmit-side counterpart of the SJA1000 FD receiver's bit timing and destuffing logic. It takes unstuffed frame bits from an upstream framer through a valid/ready handshake, inserts dynamic stuff bits, times each bit with nominal or data-phase (BRS) timing, and drives `tx_o`. It checks the wired-AND bus (`rx_i`) at each sample point for arbitration loss and bit errors.

## Interface
- `SYNC_STAGES`, default 2: flops in the `rx_i` synchronizer.
- `clk_i` in 1: system clock.
- `res_n` in 1: asynchronous active-low reset.
- `enable_i` in 1: transmitter enabled. Low aborts immediately.
- `brp_nom_i` in 6: nominal prescaler. tq = 2*(brp+1) clocks.
- `tseg1_nom_i` in 4, `tseg2_nom_i` in 3: nominal segments. Lengths are (tseg1+1) tq and (tseg2+1) tq.
- `brp_fd_i` in 6, `tseg1_fd_i` in 4, `tseg2_fd_i` in 3: data-phase timing.
- `bit_i` in 1: frame bit (1 = recessive).
- `bit_valid_i` in 1: `bit_i` and the per-bit flags are valid.
- `bit_ready_o` out 1: block accepts a bit this cycle.
- `stuff_en_i` in 1: bit lies in the dynamic-stuffing region.
- `fd_phase_i` in 1: bit uses data-phase timing.
- `arb_i` in 1: bit lies in the arbitration field.
- `last_i` in 1: final bit of the frame.
- `rx_i` in 1: bus level, asynchronous.
- `tx_o` out 1: bus drive (1 = recessive).
- `busy_o` out 1: frame in progress.
- `done_o` out 1: one-cycle pulse, frame completed.
- `arb_lost_o`, `bit_err_o`, `underrun_o` out 1 each: one-cycle pulses.

## Operation
- Reset values:
  - `tx_o`=1.
  - All other outputs 0.
  - State IDLE; stuff counter 0; last-bit register 1.
- Bit time N = 2*(brp+1)*(tseg1+tseg2+3) clocks. The sync segment is 1 tq.
- Sample point S = 2*(brp+1)*(tseg1+2) clocks after bit start. Timing parameters are latched per bit at acceptance.
- States:
  - IDLE: `bit_ready_o` = `enable_i`. On accept, go to BIT.
  - BIT: drive the latched bit for N clocks.
    - At clock S, compare the synchronized rx against the driven bit.
    - In the final clock, decide stuff / fetch / done.
  - STUFF: drive the complement of the previous bit for N clocks. Use the timing of the preceding bit. Nothing is consumed from the framer.
- Stuffing:
  - The counter counts consecutive equal transmitted bits whose `stuff_en_i`=1. A stuff bit is inserted after the 5th equal bit.
  - The stuff bit restarts the run at count 1 with its own value.
  - A bit with `stuff_en_i`=0 clears the counter to 0.
  - No stuff bit follows a bit with `last_i`=1.
  - Fixed FD CRC stuff bits are supplied by the framer with `stuff_en_i`=0.
- Final clock of BIT or STUFF:
  - If a stuff bit is due, go to STUFF.
  - Else if the last bit was `last_i`: pulse `done_o`, go to IDLE.
  - Else assert `bit_ready_o`. If `bit_valid_i`=0, pulse `underrun_o` and go to IDLE.
- Checks at the sample point:
  - Driven 1, sampled 0, `arb_i`=1: pulse `arb_lost_o`, `tx_o`=1, go to IDLE immediately.
  - Any other mismatch on a nominal-phase bit: pulse `bit_err_o`, continue. Error-frame handling belongs upstream.
  - Bits with `fd_phase_i`=1 are not checked. TDC is out of scope.
- `enable_i` low: go to IDLE next clock, `tx_o`=1, no pulse.
- `busy_o`=1 in BIT and STUFF.

## Timing
- `tx_o` takes the accepted bit one clock after the handshake. The bit holds exactly N clocks.
- Consecutive bits are gap-free: `bit_ready_o` is asserted in the final clock of the current bit.
- A BRS switch takes effect on the first bit accepted with `fd_phase_i`=1. No partial bits.
- The sample uses the rx value after `SYNC_STAGES` flops, taken at clock S.
- Simultaneous arbitration loss and `enable_i` low: `arb_lost_o` still pulses.
- Reset mid-frame: outputs return to reset values asynchronously.

## Structure
- Package `can_fd_tx_pkg`:
  - state enum {IDLE, BIT, STUFF}.
  - Struct `bit_timing_t` {brp, tseg1, tseg2}.
  - Constant STUFF_LIMIT=5.
- Submodule `can_fd_tq_timer`:
  - Loads a `bit_timing_t` at bit start.
  - Contains the prescaler and quantum counter.
  - Outputs `sample_pt` and `bit_end` one-cycle strobes.

## Test plan
- Nominal timing brp=0, tseg1=3, tseg2=2 (N=16, S=10); framer sends 1,0,1 with `last_i` on the third bit -> `tx_o` holds each bit 16 clocks, `done_o` pulses after clock 48.
- Six 0s with `stuff_en_i`=1 -> `tx_o` shows 00000 1 0: a stuff bit after the 5th 0, then the 6th 0. Exactly 6 handshakes.
- Nominal bit then `fd_phase_i`=1 bits with fd brp=0, tseg1=1, tseg2=0 (N=8) -> first FD bit lasts 8 clocks. Forced rx mismatch on the FD bit -> no `bit_err_o`.
- Drive 1 with `arb_i`=1 while the bench forces rx=0 -> `arb_lost_o` at clock 10 of the bit, `tx_o`=1 next clock, `busy_o`=0.
- `bit_valid_i` low at a bit boundary -> `underrun_o` pulse, IDLE. Same mismatch with `arb_i`=0 -> `bit_err_o` pulse, transmission continues.
- `res_n` low mid-bit -> `tx_o`=1 and all pulses 0 immediately. The next frame starts with stuff count 0.
